// File: rtl/z80_io_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : z80_io_bridge
//  Description : Bus glue between tv80n pins, on-chip RAM and a byte-stream
//                console. Provides edge-detected I/O strobes, a TX FIFO with
//                wait_n back-pressure, an RX holding register, a
//                status/control port and a level interrupt.
//  Revision    : 1.0  initial release
// ============================================================================
module z80_io_bridge #(
   parameter int         RAM_AW       = 10,
   parameter int         TX_DEPTH     = 16,
   parameter logic [7:0] DATA_PORT    = 8'hBB,
   parameter logic [7:0] STAT_PORT    = 8'hBC,
   parameter bit         WAIT_ON_FULL = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [15:0]       address,
   input  logic [7:0]        cpu_dout,
   input  logic              rd_n,
   input  logic              wr_n,
   input  logic              mreq_n,
   input  logic              iorq_n,
   input  logic              m1_n,
   output logic [7:0]        cpu_din,
   output logic              wait_n,
   output logic              int_n,
   output logic              mem_we,
   output logic [RAM_AW-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   input  logic [7:0]        mem_rdata,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready
);

   localparam int         PW      = $clog2(TX_DEPTH);
   localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_STALL = 2'd1,
      S_HOLD  = 2'd2
   } state_t;

   // ------------------------------------------------------------------
   // Bus decode
   // ------------------------------------------------------------------
   logic       io_cyc;
   logic       io_wr;
   logic       io_rd;
   logic [7:0] port;
   logic       in_ram;

   // Interrupt-acknowledge cycles (M1 with IORQ) are not port accesses.
   assign io_cyc = !iorq_n && m1_n;
   assign io_wr  = io_cyc && !wr_n;
   assign io_rd  = io_cyc && !rd_n;
   assign port   = address[7:0];
   assign in_ram = ((address >> RAM_AW) == 16'd0);

   assign mem_we    = !mreq_n && !wr_n && in_ram;
   assign mem_addr  = address[RAM_AW-1:0];
   assign mem_wdata = cpu_dout;

   // ------------------------------------------------------------------
   // Strobe edge detection
   // ------------------------------------------------------------------
   logic io_wr_q;
   logic rd_data_now;
   logic rd_data_q;
   logic wr_rise;
   logic rx_pop;
   logic stat_wr;

   assign rd_data_now = io_rd && (port == DATA_PORT);

   // Previous-strobe trackers simply follow the pins, also through reset, so a
   // bus cycle that straddles reset release is not mistaken for a new access.
   always_ff @(posedge clk) begin
      io_wr_q   <= io_wr;
      rd_data_q <= rd_data_now;
   end

   assign wr_rise = io_wr && !io_wr_q;
   assign rx_pop  = rd_data_q && !rd_data_now;
   assign stat_wr = wr_rise && (port == STAT_PORT);

   // ------------------------------------------------------------------
   // TX FIFO (pointers carry an extra wrap bit)
   // ------------------------------------------------------------------
   logic [7:0]  fifo_mem [TX_DEPTH];
   logic [PW:0] wptr;
   logic [PW:0] rptr;
   logic        tx_empty;
   logic        tx_full;
   logic        push;
   logic        pop;
   logic [7:0]  push_data;

   assign tx_empty = (wptr == rptr);
   assign tx_full  = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);
   assign tx_valid = !tx_empty;
   assign tx_data  = fifo_mem[rptr[PW-1:0]];
   assign pop      = tx_valid && tx_ready;

   // Pointer update; a push and a pop in the same cycle leave the fill level unchanged.
   always_ff @(posedge clk) begin
      if (reset) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push) wptr <= wptr + PTR_ONE;
         if (pop)  rptr <= rptr + PTR_ONE;
      end
   end

   // Storage array, written at the tail slot on every push.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wptr[PW-1:0]] <= push_data;
   end

   // ------------------------------------------------------------------
   // DATA_PORT write FSM
   // ------------------------------------------------------------------
   state_t     state;
   state_t     next_state;
   logic       stall_load;
   logic       ovf_set;
   logic [7:0] stall_byte;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= next_state;
   end

   // Next state, push request and wait_n. A stalled byte may enter the FIFO
   // in the same cycle the head is drained, releasing the CPU at once.
   always_comb begin
      next_state = state;
      wait_n     = 1'b1;
      push       = 1'b0;
      push_data  = cpu_dout;
      stall_load = 1'b0;
      ovf_set    = 1'b0;
      case (state)
         S_IDLE: begin
            if (wr_rise && (port == DATA_PORT)) begin
               if (!tx_full) begin
                  push       = 1'b1;
                  next_state = S_HOLD;
               end else if (WAIT_ON_FULL) begin
                  stall_load = 1'b1;
                  next_state = S_STALL;
               end else begin
                  ovf_set    = 1'b1;
                  next_state = S_HOLD;
               end
            end
         end
         S_STALL: begin
            push_data = stall_byte;
            if (!tx_full || pop) begin
               push       = 1'b1;
               next_state = S_HOLD;
            end else begin
               wait_n = 1'b0;
            end
         end
         S_HOLD: begin
            if (!io_wr) next_state = S_IDLE;
         end
         default: next_state = S_IDLE;
      endcase
   end

   // Byte captured when a write stalls; it is what gets pushed on release.
   always_ff @(posedge clk) begin
      if (reset)           stall_byte <= 8'h00;
      else if (stall_load) stall_byte <= cpu_dout;
   end

   // ------------------------------------------------------------------
   // Control / status
   // ------------------------------------------------------------------
   logic       ie_rx;
   logic       ie_tx;
   logic       overflow;
   logic [7:0] status;

   // Interrupt enables and sticky overflow flag (bit 2 write-one-to-clear).
   always_ff @(posedge clk) begin
      if (reset) begin
         ie_rx    <= 1'b0;
         ie_tx    <= 1'b0;
         overflow <= 1'b0;
      end else begin
         if (stat_wr) begin
            ie_rx <= cpu_dout[0];
            ie_tx <= cpu_dout[1];
            if (cpu_dout[2]) overflow <= 1'b0;
         end
         if (ovf_set) overflow <= 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // RX holding register
   // ------------------------------------------------------------------
   logic [7:0] rx_buf;
   logic       rx_full;

   assign rx_ready = !rx_full;

   // Capture an offered byte when empty; a CPU pop clears it. Capture has
   // priority so a byte landing in the pop cycle is never lost.
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_buf  <= 8'h00;
         rx_full <= 1'b0;
      end else if (rx_valid && !rx_full) begin
         rx_buf  <= rx_data;
         rx_full <= 1'b1;
      end else if (rx_pop) begin
         rx_full <= 1'b0;
      end
   end

   assign status = {2'b00, ie_tx, ie_rx, tx_empty, overflow, !tx_full, rx_full};

   // Registered level interrupt.
   always_ff @(posedge clk) begin
      if (reset) int_n <= 1'b1;
      else       int_n <= !((ie_rx && rx_full) || (ie_tx && tx_empty));
   end

   // CPU read data mux.
   always_comb begin
      cpu_din = 8'hFF;
      if (io_rd && (port == DATA_PORT))      cpu_din = rx_buf;
      else if (io_rd && (port == STAT_PORT)) cpu_din = status;
      else if (!mreq_n && in_ram)            cpu_din = mem_rdata;
   end

endmodule
`default_nettype wire

// File: tb/tb_z80_io_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_z80_io_bridge
//  Description : Self-checking bench for z80_io_bridge. Instance "a" stalls on
//                a full FIFO, instance "b" drops and flags overflow.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_z80_io_bridge;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int tests    = 0;
   int failures = 0;

   logic        reset    = 1'b1;
   logic [15:0] address  = 16'h0000;
   logic [7:0]  cpu_dout = 8'h00;
   logic        rd_n = 1'b1, wr_n = 1'b1, mreq_n = 1'b1, iorq_n = 1'b1, m1_n = 1'b1;
   logic        sel = 1'b0;
   logic [7:0]  mem_rdata = 8'h00;
   logic [7:0]  rx_data   = 8'h00;
   logic        rx_valid  = 1'b0;
   logic        tx_ready_a = 1'b0, tx_ready_b = 1'b0;

   wire iorq_a  = iorq_n | sel;
   wire iorq_b  = iorq_n | ~sel;
   wire mreq_a  = mreq_n | sel;
   wire rxv_a   = rx_valid & ~sel;
   wire rxv_b   = rx_valid & sel;

   logic [7:0] cpu_din_a, cpu_din_b, tx_data_a, tx_data_b, mem_wdata_a, mem_wdata_b;
   logic [9:0] mem_addr_a, mem_addr_b;
   logic       wait_a, wait_b, int_a, int_b, mem_we_a, mem_we_b;
   logic       tx_valid_a, tx_valid_b, rx_ready_a, rx_ready_b;

   z80_io_bridge #(.WAIT_ON_FULL(1'b1)) dut_a (
      .clk(clk), .reset(reset), .address(address), .cpu_dout(cpu_dout),
      .rd_n(rd_n), .wr_n(wr_n), .mreq_n(mreq_a), .iorq_n(iorq_a), .m1_n(m1_n),
      .cpu_din(cpu_din_a), .wait_n(wait_a), .int_n(int_a), .mem_we(mem_we_a),
      .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata),
      .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
      .rx_data(rx_data), .rx_valid(rxv_a), .rx_ready(rx_ready_a));

   z80_io_bridge #(.WAIT_ON_FULL(1'b0)) dut_b (
      .clk(clk), .reset(reset), .address(address), .cpu_dout(cpu_dout),
      .rd_n(rd_n), .wr_n(wr_n), .mreq_n(1'b1), .iorq_n(iorq_b), .m1_n(m1_n),
      .cpu_din(cpu_din_b), .wait_n(wait_b), .int_n(int_b), .mem_we(mem_we_b),
      .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_rdata(8'h00),
      .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
      .rx_data(rx_data), .rx_valid(rxv_b), .rx_ready(rx_ready_b));

   // Reference model state
   logic [7:0] qa[$];
   logic [7:0] qb[$];
   logic       rx_full_m = 1'b0;
   logic [7:0] rx_buf_m  = 8'h00;
   logic       rx_known  = 1'b0;
   logic       ie_rx_m = 1'b0, ie_tx_m = 1'b0, ovf_b_m = 1'b0;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      tests++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] exp_status_a();
      return {2'b00, ie_tx_m, ie_rx_m, (qa.size() == 0), 1'b0, (qa.size() < 16), rx_full_m};
   endfunction

   // Scoreboard: every accepted TX byte must match the oldest written byte.
   always @(negedge clk) begin
      if (tx_valid_a === 1'b1 && tx_ready_a) begin
         if (qa.size() == 0) chk("tx_a_spurious_pop", 16'd1, 16'd0);
         else                chk("tx_a_data", {8'h00, tx_data_a}, {8'h00, qa.pop_front()});
      end
      if (tx_valid_b === 1'b1 && tx_ready_b) begin
         if (qb.size() == 0) chk("tx_b_spurious_pop", 16'd1, 16'd0);
         else                chk("tx_b_data", {8'h00, tx_data_b}, {8'h00, qb.pop_front()});
      end
   end

   // Instance b is only written with tx_ready_b low, so its fill level is exact.
   task automatic io_write(input logic s, input logic [7:0] p, input logic [7:0] d);
      int n;
      if (p == 8'hBB) begin
         if (!s)                  qa.push_back(d);
         else if (qb.size() < 16) qb.push_back(d);
         else                     ovf_b_m = 1'b1;
      end else if (p == 8'hBC) begin
         if (!s) begin
            ie_rx_m = d[0];
            ie_tx_m = d[1];
         end else if (d[2]) begin
            ovf_b_m = 1'b0;
         end
      end
      sel = s; address = {8'h00, p}; cpu_dout = d; m1_n = 1'b1; iorq_n = 1'b0; wr_n = 1'b0;
      @(posedge clk); #1;
      n = 0;
      while (((s ? wait_b : wait_a) !== 1'b1) && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      chk("write_wait_bound", {15'd0, n < 300}, 16'd1);
      iorq_n = 1'b1; wr_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic io_read(input logic s, input logic [7:0] p, output logic [7:0] d);
      sel = s; address = {8'h00, p}; m1_n = 1'b1; iorq_n = 1'b0; rd_n = 1'b0;
      @(negedge clk);
      d = s ? cpu_din_b : cpu_din_a;
      @(posedge clk); #1;
      iorq_n = 1'b1; rd_n = 1'b1;
      @(posedge clk); #1;
      if (p == 8'hBB && !s) rx_full_m = 1'b0;
   endtask

   task automatic rx_inject(input logic [7:0] d);
      sel = 1'b0; rx_data = d; rx_valid = 1'b1;
      @(posedge clk); #1;
      rx_valid = 1'b0;
      if (!rx_full_m) begin
         rx_full_m = 1'b1;
         rx_buf_m  = d;
         rx_known  = 1'b1;
      end
   endtask

   task automatic drain(input logic s);
      int n;
      n = 0;
      while ((s ? qb.size() : qa.size()) > 0 && n < 500) begin
         @(posedge clk); #1;
         n++;
      end
      chk("drain_bound", {15'd0, n < 500}, 16'd1);
      @(posedge clk); #1;
      chk("drain_tx_valid", {15'd0, (s ? tx_valid_b : tx_valid_a)}, 16'd0);
   endtask

   task automatic model_reset();
      qa.delete(); qb.delete();
      rx_full_m = 1'b0; rx_known = 1'b0;
      ie_rx_m = 1'b0; ie_tx_m = 1'b0; ovf_b_m = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] d, r, e;
      logic       known;
      int         op;

      // Reset
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      model_reset();
      @(negedge clk);
      chk("rst_tx_valid_a", {15'd0, tx_valid_a}, 16'd0);
      chk("rst_rx_ready_a", {15'd0, rx_ready_a}, 16'd1);
      chk("rst_wait_a", {15'd0, wait_a}, 16'd1);
      chk("rst_int_a", {15'd0, int_a}, 16'd1);
      chk("rst_tx_valid_b", {15'd0, tx_valid_b}, 16'd0);
      chk("rst_wait_b", {15'd0, wait_b}, 16'd1);
      @(posedge clk); #1;

      // Single byte through the FIFO
      tx_ready_a = 1'b1;
      io_write(1'b0, 8'hBB, 8'h41);
      repeat (3) begin @(posedge clk); #1; end
      chk("single_all_popped", qa.size(), 16'd0);
      chk("single_tx_valid", {15'd0, tx_valid_a}, 16'd0);
      io_read(1'b0, 8'hBC, d);
      chk("single_status", {8'h00, d}, 16'h000A);

      // 17 bytes with stall
      tx_ready_a = 1'b0;
      for (int i = 0; i < 16; i++) io_write(1'b0, 8'hBB, 8'(i));
      io_read(1'b0, 8'hBC, d);
      chk("full_status", {8'h00, d}, 16'h0000);
      fork
         io_write(1'b0, 8'hBB, 8'h10);
         begin
            repeat (4) @(posedge clk);
            #1;
            chk("stall_wait_low", {15'd0, wait_a}, 16'd0);
            tx_ready_a = 1'b1;
            @(negedge clk);
            chk("stall_release", {15'd0, wait_a}, 16'd1);
         end
      join
      drain(1'b0);

      // Overflow on the dropping instance
      tx_ready_b = 1'b0;
      for (int i = 0; i < 17; i++) io_write(1'b1, 8'hBB, 8'(i));
      io_read(1'b1, 8'hBC, d);
      chk("ovf_status", {8'h00, d}, 16'h0004);
      io_write(1'b1, 8'hBC, 8'h04);
      io_read(1'b1, 8'hBC, d);
      chk("ovf_cleared", {8'h00, d}, 16'h0000);
      chk("ovf_queue_len", qb.size(), 16'd16);
      tx_ready_b = 1'b1;
      drain(1'b1);
      tx_ready_b = 1'b0;

      // RX holding register
      rx_inject(8'h5A);
      chk("rx_ready_full", {15'd0, rx_ready_a}, 16'd0);
      io_read(1'b0, 8'hBB, d);
      chk("rx_data", {8'h00, d}, 16'h005A);
      chk("rx_ready_popped", {15'd0, rx_ready_a}, 16'd1);
      io_read(1'b0, 8'hBB, d);
      chk("rx_stale", {8'h00, d}, 16'h005A);
      chk("rx_stale_ready", {15'd0, rx_ready_a}, 16'd1);

      // RX interrupt and IACK
      io_write(1'b0, 8'hBC, 8'h01);
      rx_inject(8'h33);
      @(negedge clk);
      chk("int_latency", {15'd0, int_a}, 16'd1);
      @(negedge clk);
      chk("int_asserted", {15'd0, int_a}, 16'd0);
      @(posedge clk); #1;
      sel = 1'b0; address = 16'h00BB; m1_n = 1'b0; iorq_n = 1'b0; rd_n = 1'b0;
      @(negedge clk);
      chk("iack_din", {8'h00, cpu_din_a}, 16'h00FF);
      @(posedge clk); #1;
      iorq_n = 1'b1; rd_n = 1'b1; m1_n = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      chk("iack_no_pop", {15'd0, rx_ready_a}, 16'd0);
      chk("iack_int_held", {15'd0, int_a}, 16'd0);
      io_read(1'b0, 8'hBB, d);
      chk("int_rx_data", {8'h00, d}, 16'h0033);
      @(posedge clk); #1;
      chk("int_released", {15'd0, int_a}, 16'd1);
      io_write(1'b0, 8'hBC, 8'h00);

      // Memory decode
      sel = 1'b0; mreq_n = 1'b0; wr_n = 1'b0; address = 16'h03FF; cpu_dout = 8'h77;
      @(negedge clk);
      chk("mem_we_in", {15'd0, mem_we_a}, 16'd1);
      chk("mem_addr", {6'd0, mem_addr_a}, 16'h03FF);
      chk("mem_wdata", {8'h00, mem_wdata_a}, 16'h0077);
      address = 16'h0400;
      @(negedge clk);
      chk("mem_we_out", {15'd0, mem_we_a}, 16'd0);
      wr_n = 1'b1; rd_n = 1'b0;
      @(negedge clk);
      chk("mem_rd_out", {8'h00, cpu_din_a}, 16'h00FF);
      address = 16'h0123; mem_rdata = 8'hC3;
      @(negedge clk);
      chk("mem_rd_in", {8'h00, cpu_din_a}, 16'h00C3);
      rd_n = 1'b1; mreq_n = 1'b1;
      @(posedge clk); #1;

      // Randomized traffic on instance a
      for (int k = 0; k < 300; k++) begin
         op = int'($urandom_range(0, 5));
         r  = 8'($urandom_range(0, 255));
         case (op)
            0, 1: begin
               tx_ready_a = (qa.size() >= 14) ? 1'b1 : 1'($urandom_range(0, 1));
               io_write(1'b0, 8'hBB, r);
            end
            2: begin
               tx_ready_a = 1'b0;
               repeat (2) begin @(posedge clk); #1; end
               chk("rnd_int", {15'd0, int_a},
                   {15'd0, !((ie_rx_m && rx_full_m) || (ie_tx_m && qa.size() == 0))});
               e = exp_status_a();
               io_read(1'b0, 8'hBC, d);
               chk("rnd_status", {8'h00, d}, {8'h00, e});
            end
            3: io_write(1'b0, 8'hBC, {5'd0, r[2:0]});
            4: begin
               rx_inject(r);
               chk("rnd_rx_ready", {15'd0, rx_ready_a}, {15'd0, !rx_full_m});
            end
            default: begin
               known = rx_known;
               e     = rx_buf_m;
               io_read(1'b0, 8'hBB, d);
               if (known) chk("rnd_rx_data", {8'h00, d}, {8'h00, e});
               chk("rnd_rx_ready_after", {15'd0, rx_ready_a}, 16'd1);
            end
         endcase
      end
      tx_ready_a = 1'b1;
      drain(1'b0);

      // Reset while stalled
      tx_ready_a = 1'b0;
      for (int i = 0; i < 16; i++) io_write(1'b0, 8'hBB, 8'(8'h80 + i));
      fork
         io_write(1'b0, 8'hBB, 8'hEE);
         begin
            repeat (3) @(posedge clk);
            #1;
            chk("rst_stall_wait_low", {15'd0, wait_a}, 16'd0);
            reset = 1'b1;
            @(posedge clk);
            #1 reset = 1'b0;
            model_reset();
            @(negedge clk);
            chk("rst_stall_wait_high", {15'd0, wait_a}, 16'd1);
            chk("rst_stall_empty", {15'd0, tx_valid_a}, 16'd0);
         end
      join
      repeat (3) begin @(posedge clk); #1; end
      chk("rst_stall_discard", {15'd0, tx_valid_a}, 16'd0);
      io_read(1'b0, 8'hBC, d);
      chk("rst_stall_status", {8'h00, d}, 16'h000A);

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/z80_io_bridge.md
Name: z80_io_bridge

Overview:
Synchronous bus glue between the tv80n core pins and on-chip RAM plus a byte-stream console. It replaces the ad-hoc async character latch with three parts: edge-detected I/O strobes, a parametrised TX FIFO with back-pressure via wait_n, and an RX holding register. It adds a status/control port and a level interrupt. It sits directly under z80_system, beside the memory instance and the serial TX/RX engines.

Parameters:
RAM_AW, 10, RAM address width; RAM occupies 0 .. 2^RAM_AW-1
TX_DEPTH, 16, TX FIFO entries, power of two, >=2
DATA_PORT, 8'hBB, I/O port for console data (write = TX push, read = RX pop)
STAT_PORT, 8'hBC, I/O port for status (read) / control (write)
WAIT_ON_FULL, 1, 1 = stall CPU on write to full FIFO; 0 = drop byte and set overflow

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
address  in  16  CPU address bus
cpu_dout  in  8  CPU write data
rd_n, wr_n, mreq_n, iorq_n, m1_n  in  1 each  CPU strobes, active low
cpu_din  out  8  read data to CPU
wait_n  out  1  CPU wait, active low
int_n  out  1  CPU interrupt, active low, level
mem_we  out  1  RAM write enable
mem_addr  out  RAM_AW  RAM address = address[RAM_AW-1:0]
mem_wdata  out  8  = cpu_dout
mem_rdata  in  8  RAM read data (synchronous RAM, 1-cycle)
tx_data  out  8  FIFO head byte
tx_valid  out  1  FIFO not empty
tx_ready  in  1  consumer accepts head when tx_valid && tx_ready
rx_data  in  8  received byte
rx_valid  in  1  byte offered
rx_ready  out  1  = !rx_full

Behaviour:
- Reset: FIFO empty (tx_valid=0), rx_full=0 (rx_ready=1), overflow=0, ie_rx=ie_tx=0, wait_n=1, int_n=1, FSM IDLE.
- Decode: io_cyc = !iorq_n && m1_n (interrupt-acknowledge cycles ignored). io_wr = io_cyc && !wr_n; io_rd = io_cyc && !rd_n. Port = address[7:0].
- Strobe edges use registered previous value. Write acts on the first clk with io_wr high. Read side effect (RX pop) acts on the clk where io_rd falls.
- mem_we = !mreq_n && !wr_n && in_ram, where in_ram = (address >> RAM_AW) == 0. Combinational.
- cpu_din, combinational:
  - io_rd DATA_PORT -> rx_buf
  - io_rd STAT_PORT -> {2'b0, ie_tx, ie_rx, tx_empty, overflow, tx_not_full, rx_full}
  - !mreq_n && in_ram -> mem_rdata
  - otherwise 8'hFF
- STAT_PORT write: ie_rx <= d[0]; ie_tx <= d[1]; d[2]=1 clears overflow (W1C).
- Write FSM for DATA_PORT:
  - IDLE: on io_wr rising edge to DATA_PORT:
    - FIFO not full -> push cpu_dout, go HOLD.
    - full and WAIT_ON_FULL=1 -> go STALL.
    - full and WAIT_ON_FULL=0 -> overflow<=1, no push, go HOLD.
  - STALL: wait_n=0; data captured at stall entry. When FIFO not full, push captured byte, wait_n=1 the same cycle, go HOLD.
  - HOLD: return to IDLE when io_wr drops.
  - wait_n=1 in all other states.
- FIFO: pointers with extra wrap bit, count 0..TX_DEPTH.
  - Simultaneous push and pop: count unchanged; push while full-then-pop in the same cycle is allowed (STALL exits).
  - tx_data valid combinationally from the head entry.
- RX: when rx_valid && !rx_full, rx_buf <= rx_data and rx_full <= 1. Pop on io_rd falling edge to DATA_PORT clears rx_full. Pop and capture in the same cycle: capture wins, rx_full stays 1.
- Reading DATA_PORT with rx_full=0 returns stale rx_buf with no side effect.
- int_n = !((ie_rx && rx_full) || (ie_tx && tx_empty)), registered (1-cycle latency).
- Reset asserted mid-STALL: FSM to IDLE, wait_n=1 next clk, captured byte discarded.

Test Plan:
- Reset, then write 0x41 to port 0xBB, tx_ready=1 -> tx_valid pulses with tx_data=0x41, exactly one pop; status read = 0x0A.
- tx_ready=0, write 17 bytes 0x00..0x10 (WAIT_ON_FULL=1) -> 16 accepted, 17th holds wait_n=0. Raise tx_ready -> wait_n=1 within 1 clk after first pop; bytes drained in order 0x00..0x10.
- Same with WAIT_ON_FULL=0 -> 17th dropped, status bit2=1. Write 0x04 to 0xBC -> bit2=0.
- rx_valid with rx_data=0x5A -> rx_ready=0. IN from 0xBB returns 0x5A; after rd_n rises rx_ready=1. Second read has no pop.
- Write 0x01 to 0xBC, then inject RX byte -> int_n low 1 clk after rx_full; after read it goes high. IACK cycle (m1_n=0, iorq_n=0) to port 0xBB causes no pop.
- mreq write 0x77 at 0x03FF -> mem_we=1. Write at 0x0400 -> mem_we=0; read at 0x0400 returns 0xFF.
